// File: rtl/cc_adapt_pkg.sv
// cc_adapt_pkg: completion fmt/type codes, adapter FSM states and CC descriptor field offsets
package cc_adapt_pkg;
    localparam logic [7:0] CPL    = 8'h0A;
    localparam logic [7:0] CPLD   = 8'h4A;
    localparam logic [7:0] CPLLK  = 8'h0B;
    localparam logic [7:0] CPLDLK = 8'h4B;
    typedef enum logic [1:0] {SOP, BODY, DROP} cc_state_e;
    localparam int LA_LSB   = 0;
    localparam int BC_LSB   = 16;
    localparam int LOCK_BIT = 29;
    localparam int DWC_LSB  = 32;
    localparam int STAT_LSB = 43;
    localparam int POIS_BIT = 46;
    localparam int RID_LSB  = 48;
    localparam int TAG_LSB  = 64;
    localparam int CID_LSB  = 72;
    localparam int TC_LSB   = 89;
    localparam int ATTR_LSB = 92;
    localparam int TD_BIT   = 95;
    localparam int HDR_W    = 96;
    function automatic logic is_cpl(input logic [7:0] ft);
        return ft == CPL || ft == CPLD || ft == CPLLK || ft == CPLDLK;
    endfunction
    function automatic logic is_locked(input logic [7:0] ft);
        return ft == CPLLK || ft == CPLDLK;
    endfunction
endpackage

// File: rtl/axis_skid_reg.sv
// axis_skid_reg: 2-entry AXIS skid register, entry 0 drives the output, ready is registered
module axis_skid_reg #(
    parameter int W = 8
) (
    input  logic         user_clk,
    input  logic         user_reset_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [1:0]   cnt, cnt_nxt;
    logic [W-1:0] d1;
    logic         pop;
    assign out_valid = cnt != 2'd0;
    assign pop       = out_valid && out_ready;
    assign cnt_nxt   = cnt + {1'b0, in_valid} - {1'b0, pop};
    // ready looks at the next occupancy so a push into the last free slot drops it immediately
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            cnt      <= 2'd0;
            in_ready <= 1'b0;
            out_data <= '0;
            d1       <= '0;
        end else begin
            cnt      <= cnt_nxt;
            in_ready <= cnt_nxt != 2'd2;
            if (pop || cnt == 2'd0) out_data <= (cnt == 2'd2) ? d1 : in_data;
            if (cnt != 2'd2) d1 <= in_data;
        end
    end
endmodule

// File: rtl/s_axis_cc_adapt_gen.sv
// s_axis_cc_adapt_gen: LitePCIe completion TLPs to hard-core CC descriptors, drops non-completions
module s_axis_cc_adapt_gen
    import cc_adapt_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DW_WIDTH   = DATA_WIDTH / 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  user_clk,
    input  logic                  user_reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_cc_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_cc_tkeep,
    input  logic                  s_axis_cc_tlast,
    input  logic [3:0]            s_axis_cc_tuser,
    input  logic                  s_axis_cc_tvalid,
    output logic                  s_axis_cc_tready,
    output logic [DATA_WIDTH-1:0] s_axis_cc_tdata_a,
    output logic [DW_WIDTH-1:0]   s_axis_cc_tkeep_a,
    output logic                  s_axis_cc_tlast_a,
    output logic [32:0]           s_axis_cc_tuser_a,
    output logic                  s_axis_cc_tvalid_a,
    input  logic [3:0]            s_axis_cc_tready_a,
    output logic                  drop_pulse,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);
    localparam int PW = DATA_WIDTH + DW_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    if (DATA_WIDTH != 128 && DATA_WIDTH != 256 && DATA_WIDTH != 512) begin : g_bad_width
        $error("s_axis_cc_adapt_gen: DATA_WIDTH must be 128, 256 or 512");
    end
    cc_state_e             state;
    logic                  sop, legal, emit, accept, drop_sop, disc_o, unused;
    logic [HDR_W-1:0]      hdr;
    logic [DATA_WIDTH-1:0] data_o;
    logic [DW_WIDTH-1:0]   keep_dw;
    assign unused   = ^{s_axis_cc_tready_a[3:1], s_axis_cc_tuser[2:1]};
    assign sop      = state == SOP;
    assign legal    = is_cpl(s_axis_cc_tdata[31:24]);
    assign emit     = sop ? legal : state == BODY;
    assign accept   = s_axis_cc_tvalid && s_axis_cc_tready;
    assign drop_sop = accept && sop && !legal;
    always_comb begin
        hdr                   = '0;
        hdr[LA_LSB +: 7]      = s_axis_cc_tdata[70:64];
        hdr[BC_LSB +: 13]     = {1'b0, s_axis_cc_tdata[43:32]};
        hdr[LOCK_BIT]         = is_locked(s_axis_cc_tdata[31:24]);
        hdr[DWC_LSB +: 10]    = s_axis_cc_tdata[9:0];
        hdr[STAT_LSB +: 3]    = s_axis_cc_tdata[47:45];
        hdr[POIS_BIT]         = s_axis_cc_tdata[14];
        hdr[RID_LSB +: 16]    = s_axis_cc_tdata[95:80];
        hdr[TAG_LSB +: 8]     = s_axis_cc_tdata[79:72];
        hdr[CID_LSB +: 16]    = s_axis_cc_tdata[63:48];
        hdr[TC_LSB +: 3]      = s_axis_cc_tdata[22:20];
        hdr[ATTR_LSB +: 3]    = {1'b0, s_axis_cc_tdata[13:12]};
        hdr[TD_BIT]           = s_axis_cc_tdata[15] | s_axis_cc_tuser[0];
    end
    for (genvar i = 0; i < DW_WIDTH; i++) begin : g_keep
        assign keep_dw[i] = |s_axis_cc_tkeep[4*i +: 4];
    end
    assign data_o            = sop ? {s_axis_cc_tdata[DATA_WIDTH-1:HDR_W], hdr} : s_axis_cc_tdata;
    assign s_axis_cc_tuser_a = {32'b0, disc_o};
    axis_skid_reg #(.W(PW)) u_skid (
        .user_clk     (user_clk),
        .user_reset_n (user_reset_n),
        .in_data      ({s_axis_cc_tuser[3], keep_dw, s_axis_cc_tlast, data_o}),
        .in_valid     (accept && emit),
        .in_ready     (s_axis_cc_tready),
        .out_data     ({disc_o, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tdata_a}),
        .out_valid    (s_axis_cc_tvalid_a),
        .out_ready    (s_axis_cc_tready_a[0])
    );
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state      <= SOP;
            drop_pulse <= 1'b0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (accept) state <= s_axis_cc_tlast ? SOP : sop ? (legal ? BODY : DROP) : state;
            drop_pulse <= drop_sop;
            if (accept && emit && s_axis_cc_tlast && pkt_count != '1) pkt_count <= pkt_count + ONE;
            if (drop_sop && drop_count != '1) drop_count <= drop_count + ONE;
        end
    end
endmodule

// File: tb/tb_s_axis_cc_adapt_gen.sv
// tb_s_axis_cc_adapt_gen: directed checks of the CC adapter at 128 and 256 bits
module tb_s_axis_cc_adapt_gen;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    int checks = 0, errors = 0;

    logic [255:0] tdata, tdata_a;
    logic [31:0]  tkeep;
    logic [7:0]   tkeep_a;
    logic         tlast, tvalid, tready, tlast_a, tvalid_a, drop_pulse;
    logic [3:0]   tuser, tready_a;
    logic [32:0]  tuser_a;
    logic [15:0]  pkt_count, drop_count;

    logic [127:0] n_tdata, n_tdata_a;
    logic [15:0]  n_tkeep;
    logic [3:0]   n_tkeep_a;
    logic         n_tlast, n_tvalid, n_tready, n_tlast_a, n_tvalid_a, n_drop_pulse;
    logic [3:0]   n_tuser, n_tready_a;
    logic [32:0]  n_tuser_a;
    logic [15:0]  n_pkt_count, n_drop_count;

    s_axis_cc_adapt_gen #(.DATA_WIDTH(256)) dut (
        .user_clk(clk), .user_reset_n(rst_n),
        .s_axis_cc_tdata(tdata), .s_axis_cc_tkeep(tkeep), .s_axis_cc_tlast(tlast),
        .s_axis_cc_tuser(tuser), .s_axis_cc_tvalid(tvalid), .s_axis_cc_tready(tready),
        .s_axis_cc_tdata_a(tdata_a), .s_axis_cc_tkeep_a(tkeep_a), .s_axis_cc_tlast_a(tlast_a),
        .s_axis_cc_tuser_a(tuser_a), .s_axis_cc_tvalid_a(tvalid_a), .s_axis_cc_tready_a(tready_a),
        .drop_pulse(drop_pulse), .pkt_count(pkt_count), .drop_count(drop_count)
    );

    s_axis_cc_adapt_gen #(.DATA_WIDTH(128)) dut128 (
        .user_clk(clk), .user_reset_n(rst_n),
        .s_axis_cc_tdata(n_tdata), .s_axis_cc_tkeep(n_tkeep), .s_axis_cc_tlast(n_tlast),
        .s_axis_cc_tuser(n_tuser), .s_axis_cc_tvalid(n_tvalid), .s_axis_cc_tready(n_tready),
        .s_axis_cc_tdata_a(n_tdata_a), .s_axis_cc_tkeep_a(n_tkeep_a), .s_axis_cc_tlast_a(n_tlast_a),
        .s_axis_cc_tuser_a(n_tuser_a), .s_axis_cc_tvalid_a(n_tvalid_a), .s_axis_cc_tready_a(n_tready_a),
        .drop_pulse(n_drop_pulse), .pkt_count(n_pkt_count), .drop_count(n_drop_count)
    );

    function automatic logic [95:0] tlp_hdr(input logic [7:0] ft, input logic [9:0] len,
                                            input logic [11:0] bc, input logic [7:0] tag,
                                            input logic [6:0] la, input logic [15:0] rid,
                                            input logic [15:0] cid);
        logic [95:0] h;
        h = '0;
        h[31:24] = ft;
        h[9:0]   = len;
        h[43:32] = bc;
        h[63:48] = cid;
        h[70:64] = la;
        h[79:72] = tag;
        h[95:80] = rid;
        return h;
    endfunction

    task automatic test_reset;
        tdata = '0; tkeep = '0; tlast = 0; tuser = 0; tvalid = 0; tready_a = 0;
        n_tdata = '0; n_tkeep = '0; n_tlast = 0; n_tuser = 0; n_tvalid = 0; n_tready_a = 0;
        #12;
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", tready); end
        checks++; if (tvalid_a !== 1'b0) begin errors++; $display("FAIL rst_tvalid_a got %b want 0", tvalid_a); end
        checks++; if (tdata_a !== 256'h0) begin errors++; $display("FAIL rst_tdata_a got %h want 0", tdata_a); end
        checks++; if (pkt_count !== 16'h0 || drop_count !== 16'h0) begin errors++; $display("FAIL rst_counts got %h/%h want 0/0", pkt_count, drop_count); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL rst_drop_pulse got %b want 0", drop_pulse); end
        checks++; if (n_tready !== 1'b0) begin errors++; $display("FAIL rst_tready128 got %b want 0", n_tready); end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got %b want 1", tready); end
        checks++; if (n_tready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise128 got %b want 1", n_tready); end
    endtask

    task automatic test_single_128;
        logic [127:0] b;
        b = {32'hDEADBEEF, tlp_hdr(8'h4A, 10'd1, 12'd4, 8'h5C, 7'h04, 16'h1234, 16'hABCD)};
        b[47:45] = 3'b010; b[22:20] = 3'b101; b[13:12] = 2'b10; b[14] = 1'b1;
        n_tdata = b; n_tkeep = '1; n_tlast = 1; n_tuser = 0; n_tvalid = 1; n_tready_a = 4'h1;
        @(posedge clk); #1;
        n_tvalid = 0;
        checks++; if (n_tvalid_a !== 1'b1) begin errors++; $display("FAIL s128_valid got %b want 1", n_tvalid_a); end
        checks++; if (n_tdata_a[71:64] !== 8'h5C) begin errors++; $display("FAIL s128_tag got %h want 5c", n_tdata_a[71:64]); end
        checks++; if (n_tdata_a[6:0] !== 7'h04) begin errors++; $display("FAIL s128_la got %h want 04", n_tdata_a[6:0]); end
        checks++; if (n_tdata_a[41:32] !== 10'd1) begin errors++; $display("FAIL s128_dwc got %h want 1", n_tdata_a[41:32]); end
        checks++; if (n_tdata_a !== {32'hDEADBEEF, 32'h2AABCD5C, 32'h12345001, 32'h00040004}) begin errors++; $display("FAIL s128_beat got %h want deadbeef2aabcd5c1234500100040004", n_tdata_a); end
        checks++; if (n_tkeep_a !== 4'hF || n_tlast_a !== 1'b1 || n_tuser_a !== 33'h0) begin errors++; $display("FAIL s128_side got keep %h last %b user %h want f 1 0", n_tkeep_a, n_tlast_a, n_tuser_a); end
        checks++; if (n_pkt_count !== 16'd1 || n_drop_count !== 16'd0 || n_drop_pulse !== 1'b0) begin errors++; $display("FAIL s128_counts got pkt %0d drop %0d pulse %b want 1 0 0", n_pkt_count, n_drop_count, n_drop_pulse); end
        @(posedge clk); #1;
        checks++; if (n_tvalid_a !== 1'b0) begin errors++; $display("FAIL s128_one_beat got %b want 0", n_tvalid_a); end
    endtask

    task automatic test_back_to_back;
        logic [255:0] b [3];
        b[0] = {160'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF_B0B1B2B3, tlp_hdr(8'h4A, 10'd13, 12'd52, 8'h21, 7'h10, 16'h0102, 16'h0304)};
        b[1] = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
        b[2] = 256'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE_FFFFFFFF_01234567;
        tready_a = 4'h1; tkeep = '1; tuser = 0;
        for (int i = 0; i < 3; i++) begin
            tdata = b[i]; tlast = (i == 2); tvalid = 1;
            checks++; if (tready !== 1'b1) begin errors++; $display("FAIL b2b_ready beat %0d got %b want 1", i, tready); end
            @(posedge clk); #1;
            checks++; if (tvalid_a !== 1'b1 || tlast_a !== (i == 2)) begin errors++; $display("FAIL b2b_valid beat %0d got v%b l%b want 1 %b", i, tvalid_a, tlast_a, i == 2); end
            if (i == 0) begin
                checks++; if (tdata_a !== {b[0][255:96], 32'h00030421, 32'h0102000D, 32'h00340010}) begin errors++; $display("FAIL b2b_hdr got %h want %h", tdata_a, {b[0][255:96], 32'h00030421, 32'h0102000D, 32'h00340010}); end
            end else begin
                checks++; if (tdata_a !== b[i]) begin errors++; $display("FAIL b2b_body beat %0d got %h want %h", i, tdata_a, b[i]); end
            end
        end
        tvalid = 0;
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL b2b_pkt got %0d want 1", pkt_count); end
    endtask

    task automatic test_drop;
        logic [255:0] c;
        tready_a = 4'h1; tkeep = '1; tuser = 0;
        tdata = {160'h0, tlp_hdr(8'h40, 10'd8, 12'd0, 8'h01, 7'h00, 16'h0, 16'h0)}; tlast = 0; tvalid = 1;
        @(posedge clk); #1;
        checks++; if (tvalid_a !== 1'b0) begin errors++; $display("FAIL drop_emit0 got %b want 0", tvalid_a); end
        checks++; if (drop_pulse !== 1'b1 || drop_count !== 16'd1) begin errors++; $display("FAIL drop_pulse_on got %b cnt %0d want 1 1", drop_pulse, drop_count); end
        tdata = 256'h5A5A5A5A_00000000_00000000_00000000_00000000_00000000_00000000_4A000001; tlast = 1;
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL drop_ready got %b want 1", tready); end
        @(posedge clk); #1;
        checks++; if (tvalid_a !== 1'b0 || drop_pulse !== 1'b0 || drop_count !== 16'd1) begin errors++; $display("FAIL drop_body got v%b pulse %b cnt %0d want 0 0 1", tvalid_a, drop_pulse, drop_count); end
        c = {160'hF00DF00D_0000FFFF_12121212_34343434_56565656, tlp_hdr(8'h0A, 10'd0, 12'd0, 8'h33, 7'h00, 16'h5555, 16'h6666)};
        tdata = c; tlast = 1;
        @(posedge clk); #1;
        tvalid = 0;
        checks++; if (tvalid_a !== 1'b1 || tlast_a !== 1'b1) begin errors++; $display("FAIL drop_next_valid got v%b l%b want 1 1", tvalid_a, tlast_a); end
        checks++; if (tdata_a !== {c[255:96], 32'h00666633, 32'h55550000, 32'h00000000}) begin errors++; $display("FAIL drop_next_beat got %h want %h", tdata_a, {c[255:96], 32'h00666633, 32'h55550000, 32'h00000000}); end
        checks++; if (pkt_count !== 16'd2 || drop_count !== 16'd1 || drop_pulse !== 1'b0) begin errors++; $display("FAIL drop_counts got pkt %0d drop %0d pulse %b want 2 1 0", pkt_count, drop_count, drop_pulse); end
    endtask

    task automatic test_stall;
        logic [255:0] b [4];
        logic [255:0] prev_d;
        logic         prev_l, prev_stall, acc, pop, seen_busy;
        int           idx, pops;
        b[0] = {160'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3_C4C4C4C4, tlp_hdr(8'h4A, 10'd20, 12'd80, 8'h99, 7'h00, 16'h0A0A, 16'h0B0B)};
        b[1] = 256'hD1D1D1D1_D1D1D1D1_D1D1D1D1_D1D1D1D1_D1D1D1D1_D1D1D1D1_D1D1D1D1_D1D1D1D1;
        b[2] = 256'hE2E2E2E2_E2E2E2E2_E2E2E2E2_E2E2E2E2_E2E2E2E2_E2E2E2E2_E2E2E2E2_E2E2E2E2;
        b[3] = 256'hF3F3F3F3_F3F3F3F3_F3F3F3F3_F3F3F3F3_F3F3F3F3_F3F3F3F3_F3F3F3F3_F3F3F3F3;
        idx = 0; pops = 0; seen_busy = 0;
        tready_a = 4'h1; tvalid = 0; tkeep = '1; tuser = 0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tready_a = {3'b000, cyc % 2 == 0};
            tvalid = idx < 4; tdata = b[idx < 4 ? idx : 3]; tlast = idx == 3;
            if (tvalid && !tready) seen_busy = 1;
            acc = tvalid && tready;
            pop = tvalid_a && tready_a[0];
            prev_stall = tvalid_a && !tready_a[0];
            prev_d = tdata_a; prev_l = tlast_a;
            if (pop) begin
                if (pops == 0) begin
                    checks++; if (tdata_a[255:96] !== b[0][255:96] || tdata_a[71:64] !== 8'h99) begin errors++; $display("FAIL stall_hdr got %h want upper %h tag 99", tdata_a, b[0][255:96]); end
                end else if (pops < 4) begin
                    checks++; if (tdata_a !== b[pops]) begin errors++; $display("FAIL stall_beat %0d got %h want %h", pops, tdata_a, b[pops]); end
                end
                checks++; if (tlast_a !== (pops == 3)) begin errors++; $display("FAIL stall_last %0d got %b want %b", pops, tlast_a, pops == 3); end
                pops++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
            if (prev_stall) begin
                checks++; if (tvalid_a !== 1'b1 || tdata_a !== prev_d || tlast_a !== prev_l) begin errors++; $display("FAIL stall_hold cyc %0d got v%b %h want 1 %h", cyc, tvalid_a, tdata_a, prev_d); end
            end
        end
        tvalid = 0; tready_a = 4'h1;
        checks++; if (pops !== 4 || idx !== 4) begin errors++; $display("FAIL stall_count got out %0d in %0d want 4 4", pops, idx); end
        checks++; if (seen_busy !== 1'b1) begin errors++; $display("FAIL stall_ready_drop got %b want 1", seen_busy); end
        checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL stall_pkt got %0d want 3", pkt_count); end
    endtask

    task automatic test_ecrc_disc;
        logic [255:0] b1;
        b1 = 256'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C_4B4B4B4B_5A5A5A5A_69696969_78787878;
        tready_a = 4'h1; tkeep = '1; tuser = 4'b0001; tlast = 0; tvalid = 1;
        tdata = {160'h0, tlp_hdr(8'h4B, 10'd2, 12'd8, 8'h44, 7'h08, 16'h0A0B, 16'h0C0D)};
        @(posedge clk); #1;
        checks++; if (tdata_a[95] !== 1'b1 || tdata_a[29] !== 1'b1) begin errors++; $display("FAIL ecrc_td_lock got td %b lock %b want 1 1", tdata_a[95], tdata_a[29]); end
        checks++; if (tuser_a !== 33'h0 || tkeep_a !== 8'hFF) begin errors++; $display("FAIL ecrc_sop_side got user %h keep %h want 0 ff", tuser_a, tkeep_a); end
        tdata = b1; tuser = 4'b1001; tkeep = 32'h00000F01; tlast = 1;
        @(posedge clk); #1;
        tvalid = 0; tuser = 0; tkeep = '1;
        checks++; if (tuser_a !== 33'h1) begin errors++; $display("FAIL disc_last got %h want 1", tuser_a); end
        checks++; if (tdata_a !== b1 || tlast_a !== 1'b1) begin errors++; $display("FAIL disc_beat got %h l%b want %h 1", tdata_a, tlast_a, b1); end
        checks++; if (tkeep_a !== 8'h05) begin errors++; $display("FAIL partial_keep got %h want 05", tkeep_a); end
        checks++; if (pkt_count !== 16'd4) begin errors++; $display("FAIL ecrc_pkt got %0d want 4", pkt_count); end
        @(posedge clk); #1;
        checks++; if (tvalid_a !== 1'b0) begin errors++; $display("FAIL disc_end got %b want 0", tvalid_a); end
    endtask

    task automatic test_reset_mid;
        tready_a = 4'h1; tkeep = '1; tuser = 0; tvalid = 1; tlast = 0;
        tdata = {160'h0, tlp_hdr(8'h4A, 10'd24, 12'd96, 8'h55, 7'h00, 16'h0, 16'h0)};
        @(posedge clk); #1;
        tdata = 256'h13579BDF_2468ACE0_13579BDF_2468ACE0_13579BDF_2468ACE0_13579BDF_2468ACE0;
        @(posedge clk); #1;
        tvalid = 0;
        checks++; if (tvalid_a !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b want 1", tvalid_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (tvalid_a !== 1'b0 || tdata_a !== 256'h0 || tlast_a !== 1'b0 || tkeep_a !== 8'h0 || tuser_a !== 33'h0) begin errors++; $display("FAIL rmid_outputs got v%b d%h want all 0", tvalid_a, tdata_a); end
        checks++; if (tready !== 1'b0 || pkt_count !== 16'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL rmid_state got rdy %b pkt %0d drop %0d want 0 0 0", tready, pkt_count, drop_count); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (tready !== 1'b1 || tvalid_a !== 1'b0) begin errors++; $display("FAIL rmid_after got rdy %b v%b want 1 0", tready, tvalid_a); end
        tdata = {160'hABABABAB_0, tlp_hdr(8'h0A, 10'd0, 12'd0, 8'h77, 7'h11, 16'h1111, 16'h2222)}; tlast = 1; tvalid = 1;
        @(posedge clk); #1;
        tvalid = 0;
        checks++; if (tvalid_a !== 1'b1 || tdata_a[95:0] !== {32'h00222277, 32'h11110000, 32'h00000011}) begin errors++; $display("FAIL rmid_hdr got v%b %h want 1 002222771111000000000011", tvalid_a, tdata_a[95:0]); end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL rmid_pkt got %0d want 1", pkt_count); end
    endtask

    initial begin
        test_reset;
        test_single_128;
        test_back_to_back;
        test_drop;
        test_stall;
        test_ecrc_disc;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
